// File: rtl/vec_pkg.sv
// Shared sizing defaults, lane count helper and lane-mode encoding for the vector lane adder.
package vec_pkg;

  localparam int unsigned WIDTH_DEF  = 24;
  localparam int unsigned LANE_W_DEF = 8;

  typedef enum logic {
    LM_FULL = 1'b0,
    LM_LANE = 1'b1
  } lane_mode_e;

  function automatic int unsigned nlanes(input int unsigned w, input int unsigned l);
    return w / l;
  endfunction

endpackage

// File: rtl/vec_lane_adder_lane_add.sv
// One LANE_W-bit slice: sum with carry-in, unsigned carry-out and signed overflow.
module lane_add #(
  parameter int unsigned LANE_W = 8
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              cin,
  output logic [LANE_W-1:0] s,
  output logic              cout,
  output logic              ovf
);

  logic [LANE_W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + (LANE_W+1)'(cin);
  assign s     = total[LANE_W-1:0];
  assign cout  = total[LANE_W];
  // Overflow when both operands share a sign the result does not.
  assign ovf   = (a[LANE_W-1] == b[LANE_W-1]) && (s[LANE_W-1] != a[LANE_W-1]);

endmodule

// File: rtl/vec_lane_adder.sv
// Registered full-width / SIMD-lane adder with carry and overflow flags.
// Define SAT_EN to build signed saturation on overflowing words or lanes.
module vec_lane_adder
  import vec_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned LANE_W = LANE_W_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic                            lane_mode,
  input  logic [WIDTH-1:0]                data_1,
  input  logic [WIDTH-1:0]                data_2,
  output logic [WIDTH-1:0]                sum,
  output logic [nlanes(WIDTH,LANE_W)-1:0] carry_out,
  output logic [nlanes(WIDTH,LANE_W)-1:0] overflow,
  output logic                            out_valid
);

  localparam int unsigned NLANES = nlanes(WIDTH, LANE_W);

  logic [WIDTH-1:0]  raw_sum;
  logic [NLANES-1:0] cout_w;
  logic [NLANES-1:0] ovf_w;
  logic [NLANES-1:0] cin_w;
  logic              is_lane;

  logic [WIDTH-1:0]  sum_c;
  logic [NLANES-1:0] carry_c;
  logic [NLANES-1:0] ovf_c;

  assign is_lane = (lane_mode == LM_LANE);

  // Lane slices; the carry chain is broken at every boundary in lane mode.
  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    if (i == 0) begin : g_cin0
      assign cin_w[i] = 1'b0;
    end else begin : g_cinn
      assign cin_w[i] = is_lane ? 1'b0 : cout_w[i-1];
    end

    lane_add #(.LANE_W(LANE_W)) u_lane (
      .a    (data_1[i*LANE_W +: LANE_W]),
      .b    (data_2[i*LANE_W +: LANE_W]),
      .cin  (cin_w[i]),
      .s    (raw_sum[i*LANE_W +: LANE_W]),
      .cout (cout_w[i]),
      .ovf  (ovf_w[i])
    );
  end

`ifdef SAT_EN
  localparam logic [LANE_W-1:0] LANE_MAX = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] LANE_MIN = {1'b1, {(LANE_W-1){1'b0}}};
  localparam logic [WIDTH-1:0]  WORD_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]  WORD_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // Flag selection by mode plus optional saturation of the result.
  always_comb begin
    sum_c   = raw_sum;
    carry_c = '0;
    ovf_c   = '0;
    if (is_lane) begin
      carry_c = cout_w;
      ovf_c   = ovf_w;
    end else begin
      carry_c[NLANES-1] = cout_w[NLANES-1];
      ovf_c[NLANES-1]   = ovf_w[NLANES-1];
    end
`ifdef SAT_EN
    // On overflow both operands share a sign, so data_1's MSB picks the rail.
    if (is_lane) begin
      for (int i = 0; i < NLANES; i++) begin
        if (ovf_w[i]) begin
          sum_c[i*LANE_W +: LANE_W] = data_1[i*LANE_W + LANE_W - 1] ? LANE_MIN : LANE_MAX;
        end
      end
    end else if (ovf_w[NLANES-1]) begin
      sum_c = data_1[WIDTH-1] ? WORD_MIN : WORD_MAX;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      carry_out <= '0;
      overflow  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum       <= sum_c;
        carry_out <= carry_c;
        overflow  <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_vec_lane_adder.sv
// Directed self-checking bench for vec_lane_adder; expectations follow SAT_EN when defined.
module tb_vec_lane_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        lane_mode;
  logic [23:0] data_1;
  logic [23:0] data_2;
  logic [23:0] sum;
  logic [2:0]  carry_out;
  logic [2:0]  overflow;
  logic        out_valid;

  int unsigned n_vec;
  int unsigned n_bad;

  vec_lane_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .lane_mode (lane_mode),
    .data_1    (data_1),
    .data_2    (data_2),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive at negedge, sample 1 time unit after the capturing posedge.
  task automatic apply(input logic lm, input logic [23:0] a, input logic [23:0] b);
    @(negedge clk);
    in_valid  = 1'b1;
    lane_mode = lm;
    data_1    = a;
    data_2    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [23:0] a, input logic [23:0] b);
    @(negedge clk);
    in_valid  = 1'b0;
    lane_mode = ~lane_mode;
    data_1    = a;
    data_2    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [23:0] s, input logic [2:0] c,
                            input logic [2:0] o, input logic v);
    check({tag, ".sum"}, 32'(sum), 32'(s));
    check({tag, ".carry"}, 32'(carry_out), 32'(c));
    check({tag, ".ovf"}, 32'(overflow), 32'(o));
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    lane_mode = 1'b0;
    data_1    = '0;
    data_2    = '0;
    #1;
    expect_out("reset", 24'h0, 3'b000, 3'b000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    apply(1'b0, 24'hC01401, 24'hC41403);
    expect_out("t1_full", 24'h842804, 3'b100, 3'b000, 1'b1);

    apply(1'b0, 24'hD01402, 24'hD0140B);
    expect_out("t2a_full", 24'hA0280D, 3'b100, 3'b000, 1'b1);
    apply(1'b0, 24'hC01400, 24'hC4100B);
    expect_out("t2b_full", 24'h84240B, 3'b100, 3'b000, 1'b1);

    apply(1'b1, 24'h80FF7F, 24'h80017F);
`ifdef SAT_EN
    expect_out("t3_lane", 24'h80007F, 3'b110, 3'b101, 1'b1);
`else
    expect_out("t3_lane", 24'h0000FE, 3'b110, 3'b101, 1'b1);
`endif

    // Same operands as one word: carries ripple, word overflows negative.
    apply(1'b0, 24'h80FF7F, 24'h80017F);
`ifdef SAT_EN
    expect_out("t3_full", 24'h800000, 3'b100, 3'b100, 1'b1);
`else
    expect_out("t3_full", 24'h0100FE, 3'b100, 3'b100, 1'b1);
`endif

    apply(1'b0, 24'h7FFFFF, 24'h000001);
`ifdef SAT_EN
    expect_out("t4_full", 24'h7FFFFF, 3'b000, 3'b100, 1'b1);
`else
    expect_out("t4_full", 24'h800000, 3'b000, 3'b100, 1'b1);
`endif

    apply(1'b1, 24'h0000FF, 24'h000001);
    expect_out("lane_nocarry", 24'h000000, 3'b001, 3'b000, 1'b1);
    apply(1'b0, 24'h0000FF, 24'h000001);
    expect_out("full_carry", 24'h000100, 3'b000, 3'b000, 1'b1);

    // Hold: three idle cycles with junk operands keep the last result.
    for (int i = 0; i < 3; i++) begin
      idle(24'hFFFFFF, 24'h7F7F7F);
      expect_out($sformatf("hold%0d", i), 24'h000100, 3'b000, 3'b000, 1'b0);
    end

    // Reset mid-stream with valid input: outputs clear without a clock edge.
    apply(1'b0, 24'h123456, 24'h111111);
    expect_out("pre_rst", 24'h234567, 3'b000, 3'b000, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    data_1   = 24'h7FFFFF;
    data_2   = 24'h7FFFFF;
    #2;
    rst = 1'b1;
    #1;
    expect_out("async_rst", 24'h0, 3'b000, 3'b000, 1'b0);
    @(posedge clk);
    #1;
    expect_out("rst_held", 24'h0, 3'b000, 3'b000, 1'b0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    expect_out("post_rst_idle", 24'h0, 3'b000, 3'b000, 1'b0);
    apply(1'b1, 24'h010203, 24'h040506);
    expect_out("post_rst_first", 24'h050709, 3'b000, 3'b000, 1'b1);

    @(negedge clk);
    in_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
